// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (SS.hh) clocked at 1 kHz, with start/stop/clear control.
// Build option: define BCD_STOPWATCH_LZB_EN to blank a leading zero in the tens-of-seconds digit.
//
// state   | meaning
// IDLE    | cleared, count 00.00, waiting for the first press
// RUN     | prescaler advancing, count steps every PRESCALE cycles
// STOPPED | count and prescaler held; also the saturated end state when WRAP=0
module bcd_stopwatch #(
  parameter int PRESCALE = 10,
  parameter int WRAP     = 0
) (
  input  logic       clk_1k_i,
  input  logic       rst_ni,
  input  logic       start_stop_i,
  input  logic       clear_i,
  output logic [3:0] digit0_o,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic [3:0] digit3_o,
  output logic       digit0_en_o,
  output logic       digit1_en_o,
  output logic       digit2_en_o,
  output logic       digit3_en_o,
  output logic       running_o,
  output logic       sat_o
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPED} state_t;

  localparam logic [9:0]  PRE_LAST = 10'(PRESCALE - 1);
  localparam logic [15:0] ALL_NINE = 16'h9999;

  state_t           state_q, state_d;
  logic [9:0]       pre_q, pre_d;
  logic [3:0][3:0]  dig_q, dig_d, dig_inc;
  logic             sat_q, sat_d;
  logic             ss_prev_q;
  logic             press;
  logic             carry;

  assign press = start_stop_i & ~ss_prev_q;

  always_ff @(posedge clk_1k_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      dig_q     <= '0;
      sat_q     <= 1'b0;
      ss_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      dig_q     <= dig_d;
      sat_q     <= sat_d;
      ss_prev_q <= start_stop_i;
    end
  end

  // Ripple BCD increment: a digit moves only while every lower digit is rolling over from 9.
  always_comb begin
    dig_inc = dig_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig_q[i] == 4'd9) begin
          dig_inc[i] = 4'd0;
        end else begin
          dig_inc[i] = dig_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    dig_d   = dig_q;
    sat_d   = sat_q;
    if (clear_i) begin
      state_d = IDLE;
      pre_d   = '0;
      dig_d   = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press) state_d = RUN;
        end
        RUN: begin
          if (press) state_d = STOPPED;
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (WRAP == 0 && dig_q == ALL_NINE) begin
              state_d = STOPPED;
              sat_d   = 1'b1;
            end else begin
              dig_d = dig_inc;
              if (WRAP == 0 && dig_inc == ALL_NINE) begin
                state_d = STOPPED;
                sat_d   = 1'b1;
              end
            end
          end else begin
            pre_d = pre_q + 10'd1;
          end
        end
        STOPPED: begin
          if (press && !sat_q) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign digit0_o    = dig_q[0];
  assign digit1_o    = dig_q[1];
  assign digit2_o    = dig_q[2];
  assign digit3_o    = dig_q[3];
  assign digit0_en_o = 1'b1;
  assign digit1_en_o = 1'b1;
  assign digit2_en_o = 1'b1;
`ifdef BCD_STOPWATCH_LZB_EN
  assign digit3_en_o = (dig_q[3] != 4'd0);
`else
  assign digit3_en_o = 1'b1;
`endif
  assign running_o   = (state_q == RUN);
  assign sat_o       = (WRAP == 0) ? sat_q : 1'b0;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: three instances (P=10/saturate, P=2/saturate, P=2/wrap) on shared inputs,
// checked against an integer-count reference model.
module tb_bcd_stopwatch;

  logic clk;
  logic rst_n;
  logic ss;
  logic clr;

  logic [3:0]  dg  [3][4];
  logic        en  [3][4];
  logic        run [3];
  logic        sat [3];
  logic [23:0] obs [3];

  int total = 0;
  int bad   = 0;

  // reference model: count held as a plain integer 0..9999, state 0=idle 1=run 2=stopped
  int P_T [3] = '{10, 2, 2};
  int W_T [3] = '{0, 0, 1};
  int m_state [3];
  int m_pre   [3];
  int m_cnt   [3];
  bit m_sat   [3];
  bit m_prev  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_stopwatch #(.PRESCALE(10), .WRAP(0)) u_main (
    .clk_1k_i(clk), .rst_ni(rst_n), .start_stop_i(ss), .clear_i(clr),
    .digit0_o(dg[0][0]), .digit1_o(dg[0][1]), .digit2_o(dg[0][2]), .digit3_o(dg[0][3]),
    .digit0_en_o(en[0][0]), .digit1_en_o(en[0][1]), .digit2_en_o(en[0][2]), .digit3_en_o(en[0][3]),
    .running_o(run[0]), .sat_o(sat[0]));

  bcd_stopwatch #(.PRESCALE(2), .WRAP(0)) u_sat (
    .clk_1k_i(clk), .rst_ni(rst_n), .start_stop_i(ss), .clear_i(clr),
    .digit0_o(dg[1][0]), .digit1_o(dg[1][1]), .digit2_o(dg[1][2]), .digit3_o(dg[1][3]),
    .digit0_en_o(en[1][0]), .digit1_en_o(en[1][1]), .digit2_en_o(en[1][2]), .digit3_en_o(en[1][3]),
    .running_o(run[1]), .sat_o(sat[1]));

  bcd_stopwatch #(.PRESCALE(2), .WRAP(1)) u_wrap (
    .clk_1k_i(clk), .rst_ni(rst_n), .start_stop_i(ss), .clear_i(clr),
    .digit0_o(dg[2][0]), .digit1_o(dg[2][1]), .digit2_o(dg[2][2]), .digit3_o(dg[2][3]),
    .digit0_en_o(en[2][0]), .digit1_en_o(en[2][1]), .digit2_en_o(en[2][2]), .digit3_en_o(en[2][3]),
    .running_o(run[2]), .sat_o(sat[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {dg[g][3], dg[g][2], dg[g][1], dg[g][0],
                     en[g][3], en[g][2], en[g][1], en[g][0], run[g], sat[g], 2'b00};
  end

  function automatic logic [23:0] exp_vec(int i);
    logic [3:0] d3, d2, d1, d0;
    logic       e3;
    d3 = 4'(m_cnt[i] / 1000);
    d2 = 4'((m_cnt[i] / 100) % 10);
    d1 = 4'((m_cnt[i] / 10) % 10);
    d0 = 4'(m_cnt[i] % 10);
`ifdef BCD_STOPWATCH_LZB_EN
    e3 = (d3 != 4'd0);
`else
    e3 = 1'b1;
`endif
    return {d3, d2, d1, d0, e3, 3'b111, (m_state[i] == 1), m_sat[i], 2'b00};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_state[i] = 0; m_pre[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0; m_prev[i] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit press;
    for (int i = 0; i < 3; i++) begin
      press     = ss && !m_prev[i];
      m_prev[i] = ss;
      if (clr) begin
        m_state[i] = 0; m_pre[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0;
      end else if (m_state[i] == 0) begin
        if (press) m_state[i] = 1;
      end else if (m_state[i] == 1) begin
        if (press) m_state[i] = 2;
        if (m_pre[i] == P_T[i] - 1) begin
          m_pre[i] = 0;
          if (m_cnt[i] == 9999) m_cnt[i] = (W_T[i] != 0) ? 0 : 9999;
          else m_cnt[i] = m_cnt[i] + 1;
          if (W_T[i] == 0 && m_cnt[i] == 9999) begin
            m_state[i] = 2;
            m_sat[i]   = 1'b1;
          end
        end else begin
          m_pre[i] = m_pre[i] + 1;
        end
      end else begin
        if (press && !m_sat[i]) m_state[i] = 1;
      end
    end
  endtask

  task automatic tick(int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_once();
    ss = 1'b1; tick(1); ss = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1; ss = 1'b0; tick(1); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ss = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== exp_vec(i)) begin
        bad++; $display("FAIL reset dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
      end
    end
    rst_n = 1'b1;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== exp_vec(i)) begin
        bad++; $display("FAIL reset_release dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_run30();
    press_once();
    tick(30);
    total++;
    if ({dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]} !== {16'h0003, 1'b1}) begin
      bad++; $display("FAIL run30 got=%h%h%h%h run=%b exp=0003 run=1",
                      dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== exp_vec(i)) begin
        bad++; $display("FAIL run30_model dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_stop_resume();
    do_clear();
    press_once();
    tick(15);
    total++;
    if ({dg[0][3], dg[0][2], dg[0][1], dg[0][0]} !== 16'h0001) begin
      bad++; $display("FAIL stop_pre got=%h%h%h%h exp=0001", dg[0][3], dg[0][2], dg[0][1], dg[0][0]);
    end
    press_once();
    tick(100);
    total++;
    if ({dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]} !== {16'h0001, 1'b0}) begin
      bad++; $display("FAIL stop_hold got=%h%h%h%h run=%b exp=0001 run=0",
                      dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]);
    end
    press_once();
    tick(5);
    total++;
    if ({dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]} !== {16'h0002, 1'b1}) begin
      bad++; $display("FAIL resume got=%h%h%h%h run=%b exp=0002 run=1",
                      dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== exp_vec(i)) begin
        bad++; $display("FAIL resume_model dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_sat_wrap();
    do_clear();
    press_once();
    tick(19998);
    total++;
    if ({dg[1][3], dg[1][2], dg[1][1], dg[1][0], sat[1], run[1]} !== {16'h9999, 2'b10}) begin
      bad++; $display("FAIL sat_reach got=%h%h%h%h sat=%b run=%b exp=9999 sat=1 run=0",
                      dg[1][3], dg[1][2], dg[1][1], dg[1][0], sat[1], run[1]);
    end
    total++;
    if ({dg[2][3], dg[2][2], dg[2][1], dg[2][0], sat[2], run[2]} !== {16'h9999, 2'b01}) begin
      bad++; $display("FAIL wrap_top got=%h%h%h%h sat=%b run=%b exp=9999 sat=0 run=1",
                      dg[2][3], dg[2][2], dg[2][1], dg[2][0], sat[2], run[2]);
    end
    tick(2);
    total++;
    if ({dg[2][3], dg[2][2], dg[2][1], dg[2][0], sat[2], run[2]} !== {16'h0000, 2'b01}) begin
      bad++; $display("FAIL wrap_roll got=%h%h%h%h sat=%b run=%b exp=0000 sat=0 run=1",
                      dg[2][3], dg[2][2], dg[2][1], dg[2][0], sat[2], run[2]);
    end
    press_once();
    tick(10);
    total++;
    if ({dg[1][3], dg[1][2], dg[1][1], dg[1][0], sat[1], run[1]} !== {16'h9999, 2'b10}) begin
      bad++; $display("FAIL sat_press got=%h%h%h%h sat=%b run=%b exp=9999 sat=1 run=0",
                      dg[1][3], dg[1][2], dg[1][1], dg[1][0], sat[1], run[1]);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== exp_vec(i)) begin
        bad++; $display("FAIL sat_model dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_clear_press();
    do_clear();
    press_once();
    tick(12340);
    total++;
    if ({dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]} !== {16'h1234, 1'b1}) begin
      bad++; $display("FAIL at_1234 got=%h%h%h%h run=%b exp=1234 run=1",
                      dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]);
    end
    clr = 1'b1; ss = 1'b1;
    tick(1);
    clr = 1'b0;
    total++;
    if ({dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]} !== {16'h0000, 1'b0}) begin
      bad++; $display("FAIL clear_wins got=%h%h%h%h run=%b exp=0000 run=0",
                      dg[0][3], dg[0][2], dg[0][1], dg[0][0], run[0]);
    end
    tick(10);
    total++;
    if (run[0] !== 1'b0) begin
      bad++; $display("FAIL held_after_clear run=%b exp=0", run[0]);
    end
    ss = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== exp_vec(i)) begin
        bad++; $display("FAIL clear_model dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_lzb();
    logic e3_exp;
`ifdef BCD_STOPWATCH_LZB_EN
    e3_exp = 1'b0;
`else
    e3_exp = 1'b1;
`endif
    do_clear();
    press_once();
    tick(5000);
    total++;
    if ({dg[0][3], dg[0][2], dg[0][1], dg[0][0], en[0][3]} !== {16'h0500, e3_exp}) begin
      bad++; $display("FAIL lzb_0500 got=%h%h%h%h en3=%b exp=0500 en3=%b",
                      dg[0][3], dg[0][2], dg[0][1], dg[0][0], en[0][3], e3_exp);
    end
    tick(5000);
    total++;
    if ({dg[0][3], dg[0][2], dg[0][1], dg[0][0], en[0][3]} !== {16'h1000, 1'b1}) begin
      bad++; $display("FAIL lzb_1000 got=%h%h%h%h en3=%b exp=1000 en3=1",
                      dg[0][3], dg[0][2], dg[0][1], dg[0][0], en[0][3]);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    press_once();
    tick(37);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({dg[i][3], dg[i][2], dg[i][1], dg[i][0], run[i], sat[i]} !== 18'd0) begin
        bad++; $display("FAIL async_rst dut%0d got=%h%h%h%h run=%b sat=%b exp=0000 run=0 sat=0",
                        i, dg[i][3], dg[i][2], dg[i][1], dg[i][0], run[i], sat[i]);
      end
    end
    ss = 1'b1;
    #3 rst_n = 1'b1;
    tick(20);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== exp_vec(i) || run[i] !== 1'b0) begin
        bad++; $display("FAIL held_release dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
      end
    end
    ss = 1'b0;
    tick(1);
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 400; c++) begin
      ss  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 60) == 0);
      tick(1);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== exp_vec(i)) begin
          bad++; $display("FAIL random c=%0d dut%0d got=%h exp=%h", c, i, obs[i], exp_vec(i));
        end
      end
    end
    ss = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run30();
    test_stop_resume();
    test_sat_wrap();
    test_clear_press();
    test_lzb();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
